// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier (unpack / multiply / normalise-round-pack).
// Define FP_MULT_RNE_EN for round-to-nearest-even; otherwise truncate with saturating overflow.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_p,
    output logic [3:0]           out_flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int EXW = EXP_W + 2;
    localparam logic signed [EXW-1:0] BIAS = EXW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EXW-1:0] EMAX = EXW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic s1_v, s2_v, s3_v;
    logic advance;

    // One global stall: every stage holds while the output is blocked.
    assign advance   = ~(s3_v & ~out_ready);
    assign in_ready  = advance;
    assign out_valid = s3_v;

    // ---------------- S1: unpack / classify ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;

    assign {sa, ea, fa} = in_a;
    assign {sb, eb, fb} = in_b;

    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic u_sign, u_inv_op;

    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (ea == '1) && (fa == '0);
    assign b_inf    = (eb == '1) && (fb == '0);
    assign a_nan    = (ea == '1) && (fa != '0);
    assign b_nan    = (eb == '1) && (fb != '0);
    assign a_snan   = a_nan & ~fa[MAN_W-1];
    assign b_snan   = b_nan & ~fb[MAN_W-1];
    assign u_sign   = sa ^ sb;
    assign u_inv_op = (a_inf & b_zero) | (b_inf & a_zero);

    logic                  u_spec;
    logic [W-1:0]          u_spec_p;
    logic [3:0]            u_spec_f;
    logic signed [EXW-1:0] u_exp;

    // Subnormals are classified as zero here, so FTZ falls out of the zero case.
    always_comb begin
        u_spec   = 1'b0;
        u_spec_p = '0;
        u_spec_f = 4'b0000;
        if (a_nan | b_nan | u_inv_op) begin
            u_spec   = 1'b1;
            u_spec_p = QNAN;
            u_spec_f = {a_snan | b_snan | u_inv_op, 3'b000};
        end else if (a_inf | b_inf) begin
            u_spec   = 1'b1;
            u_spec_p = {u_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
            u_spec   = 1'b1;
            u_spec_p = {u_sign, {(W-1){1'b0}}};
        end
    end

    assign u_exp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    logic                  s1_sign;
    logic signed [EXW-1:0] s1_exp;
    logic [SW-1:0]         s1_sig_a, s1_sig_b;
    logic                  s1_spec;
    logic [W-1:0]          s1_spec_p;
    logic [3:0]            s1_spec_f;

    logic                  s2_sign;
    logic signed [EXW-1:0] s2_exp;
    logic [PW-1:0]         s2_prod;
    logic                  s2_spec;
    logic [W-1:0]          s2_spec_p;
    logic [3:0]            s2_spec_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else if (advance) begin
            s1_v <= in_valid;
            s2_v <= s1_v;
            s3_v <= s2_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_sig_a  <= '0;
            s1_sig_b  <= '0;
            s1_spec   <= 1'b0;
            s1_spec_p <= '0;
            s1_spec_f <= 4'b0000;
        end else if (advance && in_valid) begin
            s1_sign   <= u_sign;
            s1_exp    <= u_exp;
            s1_sig_a  <= {1'b1, fa};
            s1_sig_b  <= {1'b1, fb};
            s1_spec   <= u_spec;
            s1_spec_p <= u_spec_p;
            s1_spec_f <= u_spec_f;
        end
    end

    // ---------------- S2: significand multiply ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_prod   <= '0;
            s2_spec   <= 1'b0;
            s2_spec_p <= '0;
            s2_spec_f <= 4'b0000;
        end else if (advance && s1_v) begin
            s2_sign   <= s1_sign;
            s2_exp    <= s1_exp;
            s2_prod   <= PW'(s1_sig_a) * PW'(s1_sig_b);
            s2_spec   <= s1_spec;
            s2_spec_p <= s1_spec_p;
            s2_spec_f <= s1_spec_f;
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic [PW-1:0]         norm;
    logic [SW-1:0]         mant;
    logic                  guard, sticky, round_up, carry, inexact, ovf, unf;
    logic [SW:0]           mant_r;
    logic [MAN_W-1:0]      mant_f;
    logic signed [EXW-1:0] e_n, e_f;

    assign norm   = s2_prod[PW-1] ? s2_prod : {s2_prod[PW-2:0], 1'b0};
    assign mant   = norm[PW-1 -: SW];
    assign guard  = norm[PW-1-SW];
    assign sticky = |norm[PW-2-SW:0];
    assign e_n    = s2_exp + $signed({{(EXW-1){1'b0}}, s2_prod[PW-1]});

`ifdef FP_MULT_RNE_EN
    assign round_up = guard & (sticky | mant[0]);
`else
    assign round_up = 1'b0;
`endif

    assign mant_r  = {1'b0, mant} + {{SW{1'b0}}, round_up};
    assign carry   = mant_r[SW];
    assign mant_f  = carry ? mant_r[SW-1:1] : mant_r[MAN_W-1:0];
    assign e_f     = e_n + $signed({{(EXW-1){1'b0}}, carry});
    assign inexact = guard | sticky;
    assign ovf     = ~e_f[EXW-1] & (e_f >= EMAX);
    assign unf     = e_f[EXW-1] | (e_f == '0);

    logic [W-1:0] res_p;
    logic [3:0]   res_f;

    always_comb begin
        res_p = {s2_sign, e_f[EXP_W-1:0], mant_f};
        res_f = {3'b000, inexact};
        if (s2_spec) begin
            res_p = s2_spec_p;
            res_f = s2_spec_f;
        end else if (ovf) begin
`ifdef FP_MULT_RNE_EN
            res_p = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
            res_p = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
            res_f = 4'b0101;
        end else if (unf) begin
            res_p = {s2_sign, {(W-1){1'b0}}};
            res_f = 4'b0011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p     <= '0;
            out_flags <= 4'b0000;
        end else if (advance && s2_v) begin
            out_p     <= res_p;
            out_flags <= res_f;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe (binary32 defaults): arithmetic reference model, scoreboard queue,
// directed literal cases, backpressure, mid-flight reset and randomized traffic.
module tb_fp_mult_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_p;
    logic [3:0]  out_flags;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    fp_mult_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_flags(out_flags)
    );

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Exact integer product, then keep 24 significant bits by division-style remainder.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, k;
        logic [22:0] fa, fb;
        logic [63:0] prod, q, rem, half;
        bit az, bz, ai, bi, an, bn, snan, inv_op;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        snan   = (an && !fa[22]) || (bn && !fb[22]);
        inv_op = (ai && bz) || (bi && az);
        if (an || bn || inv_op) return {snan || inv_op, 3'b000, 32'h7FC00000};
        if (ai || bi) return {4'b0000, s, 8'hFF, 23'h0};
        if (az || bz) return {4'b0000, s, 31'h0};
        prod = {40'd0, 1'b1, fa} * {40'd0, 1'b1, fb};
        k    = prod[47] ? 24 : 23;
        q    = prod >> k;
        half = 64'd1 << (k - 1);
        rem  = prod & ((64'd1 << k) - 64'd1);
        e    = ea + eb - 127 + (k - 23);
`ifdef FP_MULT_RNE_EN
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q[24]) begin
            q = q >> 1;
            e = e + 1;
        end
`endif
        if (e >= 255) begin
`ifdef FP_MULT_RNE_EN
            return {4'b0101, s, 8'hFF, 23'h0};
`else
            return {4'b0101, s, 8'hFE, 23'h7FFFFF};
`endif
        end
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, rem != 0, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic s;
        logic [22:0] f;
        s = 1'($urandom);
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0: return {s, 31'h0};
            1: return {s, 8'h00, (f == 0) ? 23'h1 : f};
            2: return {s, 8'hFF, 23'h0};
            3: return {s, 8'hFF, (f == 0) ? 23'h1 : f};
            4: return {s, 8'($urandom_range(200, 254)), f};
            5: return {s, 8'($urandom_range(1, 50)), f};
            default: return {s, 8'($urandom_range(100, 154)), f};
        endcase
    endfunction

    // Scoreboard / protocol monitor, sampled on the falling edge.
    initial begin
        logic stalled;
        logic [35:0] held;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                chk(in_ready === !(out_valid && !out_ready), "in_ready", 64'(in_ready),
                    64'(!(out_valid && !out_ready)));
                if (stalled)
                    chk({out_flags, out_p} === held, "hold_stable", 64'({out_flags, out_p}), 64'(held));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0 === out_valid, "spurious_out", 64'(out_p), 64'd0);
                    end else begin
                        chk(out_p === exp_q[0][31:0], "out_p", 64'(out_p), 64'(exp_q[0][31:0]));
                        chk(out_flags === exp_q[0][35:32], "out_flags", 64'(out_flags), 64'(exp_q[0][35:32]));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            out_cnt++;
                        end
                    end
                end
                stalled = out_valid && !out_ready;
                held = {out_flags, out_p};
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_a, in_b));
                    acc_cnt++;
                    chk(exp_q.size() <= 3, "in_flight", 64'(exp_q.size()), 64'd3);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk(got, "send_accept", 64'(got), 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ep, input logic [3:0] ef);
        logic [35:0] m;
        m = model(a, b);
        chk(m === {ef, ep}, "model_pin", 64'(m), 64'({ef, ep}));
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk(out_valid === 1'b0, "latency_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk(out_valid === 1'b1, "latency3", 64'(out_valid), 64'd1);
        chk(out_p === ep, "direct_p", 64'(out_p), 64'(ep));
        chk(out_flags === ef, "direct_flags", 64'(out_flags), 64'(ef));
    endtask

    function automatic logic [31:0] rand_normal();
        return {1'b0, 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] pa[5];
        logic [31:0] pb[5];
        int acc0, out0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        #12;
        chk(out_valid === 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        chk(out_p === 32'h0, "rst_out_p", 64'(out_p), 64'd0);
        chk(out_flags === 4'h0, "rst_out_flags", 64'(out_flags), 64'd0);
        chk(in_ready === 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
`ifdef FP_MULT_RNE_EN
        run_one(32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001);
        run_one(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
`else
        run_one(32'h3FC00001, 32'h3FC00001, 32'h40100001, 4'b0001);
        run_one(32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 4'b0101);
`endif
        run_one(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
        run_one(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        run_one(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);
        run_one(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        run_one(32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_one(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
        run_one(32'hBF800000, 32'h00000000, 32'h80000000, 4'b0000);
        drain();

        // Backpressure: five pairs offered against a blocked output.
        for (int i = 0; i < 5; i++) begin
            pa[i] = rand_normal();
            pb[i] = rand_normal();
        end
        out_ready = 1'b0;
        acc0 = acc_cnt;
        out0 = out_cnt;
        send(pa[0], pb[0]);
        send(pa[1], pb[1]);
        send(pa[2], pb[2]);
        in_valid = 1'b1;
        in_a = pa[3];
        in_b = pb[3];
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk(in_ready === 1'b0, "bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        chk(acc_cnt - acc0 == 3, "bp_accepted", 64'(acc_cnt - acc0), 64'd3);
        out_ready = 1'b1;
        send(pa[3], pb[3]);
        send(pa[4], pb[4]);
        drain();
        chk(out_cnt - out0 == 5, "bp_emitted", 64'(out_cnt - out0), 64'd5);

        // Reset with three items in flight.
        out_ready = 1'b1;
        send(rand_normal(), rand_normal());
        send(rand_normal(), rand_normal());
        send(rand_normal(), rand_normal());
        #2 rst_n = 1'b0;
        #1;
        chk(out_valid === 1'b0, "rst_mid_valid", 64'(out_valid), 64'd0);
        chk(out_p === 32'h0, "rst_mid_p", 64'(out_p), 64'd0);
        chk(in_ready === 1'b1, "rst_mid_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 6; n++) begin
            chk(out_valid === 1'b0, "post_rst_quiet", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        run_one(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        drain();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = rand_op();
            in_b      = rand_op();
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Pipelined, parametrised IEEE-754-style floating-point multiplier for the FFT datapath. It replaces the single-cycle combinational multiplier in the butterfly twiddle path. The block adds configurable exponent/mantissa widths, a 3-stage pipeline with valid/ready flow control, correct special-value handling, and exception flags. Default parameters give binary32.

## Interface
- `EXP_W`, 8: exponent field width (≥4).
- `MAN_W`, 23: stored fraction width (≥4); W = 1+EXP_W+MAN_W.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair this cycle.
- `in_a`, `in_b`  in  W  operands {sign, exp, frac}.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_p`  out  W  product.
- `out_flags`  out  4  {invalid, overflow, underflow, inexact}, aligned with `out_p`.

## Operation
- Bias B = 2^(EXP_W-1)-1. Exponent arithmetic is signed, EXP_W+2 bits wide. The mantissa product is 2·(MAN_W+1) bits wide.
- **S1 (unpack):**
  - sign = a.s ^ b.s.
  - Each operand is classified as zero, subnormal, normal, inf, or NaN.
  - Subnormal inputs are flushed to signed zero (FTZ). This flush sets no flags.
  - Biased exponent sum e = ea + eb − B.
- **S2 (multiply):** full product of the {1,frac} significands.
- **S3 (normalise/round/pack):**
  - If product MSB = 1: shift right 1, e+1.
  - Round per Configuration, using guard bit and sticky OR.
  - Mantissa carry-out after rounding: shift right 1, e+1.
  - e ≥ 2^EXP_W−1 → ±inf; sets overflow and inexact.
  - e ≤ 0 → ±0 (flush, no subnormal output); sets underflow and inexact.
  - Otherwise, inexact = guard | sticky.
- **Special cases** take priority over arithmetic:
  - Any NaN, or inf×0 → canonical qNaN {0, all-ones exp, MSB frac = 1, rest 0}. Sets invalid only when inf×0 or an input is a signalling NaN (frac MSB = 0).
  - inf×finite-nonzero → ±inf, no flags.
  - zero×finite → ±0, no flags.

## Timing
- Latency: 3 cycles from accepted input to `out_valid`, with no stall. Throughput is 1 per cycle.
- Stage valids are s1_v, s2_v, s3_v; `out_valid` = s3_v.
- Global stall = s3_v & ~out_ready. On stall:
  - All stage registers hold.
  - `in_ready` = ~stall, which is combinational from `out_ready`.
- A transfer occurs when in_valid & in_ready (input side) or out_valid & out_ready (output side). Both may occur in the same cycle; the pipeline advances.
- Bubbles do not collapse while stalled. A maximum of 3 results are in flight.
- Reset values: all valids 0, `out_valid` 0, `out_p` 0, `out_flags` 0. `in_ready` is 1 after reset.
- Reset asserted mid-operation discards every in-flight item. No output is produced for them.
- Data registers load only on advance, which makes the hold behaviour deterministic.
- `out_p` and `out_flags` are stable while out_valid & ~out_ready.

## Configuration
- `FP_MULT_RNE_EN` defined: round-to-nearest, ties-to-even. Round up when guard & (sticky | lsb).
- Not defined: truncate (round toward zero). Inexact is still reported.
  - In this mode, overflow saturates to the largest finite value (exp = 2^EXP_W−2, frac all-ones) instead of inf.
  - NaN, inf, and invalid handling is identical in both modes.

## Test plan
All values are binary32 defaults.
- **Basic multiply:** 0x3FC00000 × 0x40000000, out_ready=1 → 0x40400000 three cycles later; flags 0000.
- **Rounding:** 0x3FC00001 × 0x3FC00001 → 0x40100002 with RNE, 0x40100001 without; flags 0001.
- **Overflow and underflow:**
  - 0x7F000000 × 0x7F000000 → 0x7F800000 with RNE (0x7F7FFFFF without); flags 0101.
  - 0x00800000 × 0x00800000 → 0x00000000; flags 0011.
- **Special cases:**
  - 0x7F800000 × 0x00000000 → 0x7FC00000; flags 1000.
  - 0x00000001 × 0x3F800000 → 0x00000000; flags 0000.
  - 0xFF800000 × 0x40000000 → 0xFF800000; flags 0000.
- **Backpressure:** hold out_ready=0 and stream 5 pairs.
  - Exactly 3 are accepted; `in_ready` drops when s3_v sets.
  - Release out_ready → all 5 results emerge in order, with no loss or duplication.
- **Reset:** assert rst_n=0 with 3 items in flight → `out_valid` goes 0 immediately and no stale result appears afterwards. A new pair after reset yields its result at latency 3.
